spi_slave_regfile: RTL and testbench
====================================

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronisers on spi_sck_i, spi_cs_n_i and spi_mosi_i; legal values are 2 and 3.
REQ-002 Parameter REG_RESET, default 8'h00: reset value of every register.
REQ-003 One clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  in  1  system clock; all logic is in this domain.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 spi_sck_i  in  1  SPI clock from the SPIController; asynchronous to clk.
REQ-007 spi_cs_n_i  in  1  active-low chip select; asynchronous to clk.
REQ-008 spi_mosi_i  in  1  master-out data.
REQ-009 spi_miso_o  out  1  slave-out data.
REQ-010 spi_miso_oe_o  out  1  high while the synchronised CS is asserted.
REQ-011 loc_addr_i  in  4  local read/write address.
REQ-012 loc_we_i  in  1  local write enable.
REQ-013 loc_wdata_i  in  8  local write data.
REQ-014 loc_rdata_o  out  8  registered local read data.
REQ-015 wr_stb_o, wr_addr_o[3:0], wr_data_o[7:0]  out  one-cycle pulse with the SPI write address and data.
REQ-016 frame_done_o  out  1  one-cycle pulse when CS deasserts after at least one complete byte.
REQ-017 busy_o  out  1  high while the state is not IDLE.

Function
REQ-018 SPI mode 0, MSB first: MOSI is sampled on the detected rising SCK edge; MISO is updated on the detected falling SCK edge; SCK is at most clk/8.
REQ-019 Edge detection runs on the synchronised signals; the sample point is SYNC_STAGES+1 clk cycles after the pin edge.
REQ-020 State machine has the states IDLE, CMD and DATA.
REQ-021 IDLE goes to CMD on a CS fall; CMD goes to DATA after the 8th rising edge; DATA stays in DATA per byte; any state goes to IDLE on a CS rise.
REQ-022 Command byte: bit7 = 1 is a read and 0 is a write; bits 3:0 are the start address; bits 6:4 are ignored.
REQ-023 A 3-bit bit counter is cleared on a CS fall and wraps every 8 rising edges.
REQ-024 Write, on the 8th rising edge of each data byte: reg[addr] is written, wr_stb_o pulses the following cycle with that address and data, and addr increments mod 16.
REQ-025 Read, on the first falling edge after each completed byte (command or data): reg[addr] loads into the TX shifter, spi_miso_o presents its MSB, and addr increments mod 16.
REQ-026 Read, on the remaining falling edges: the TX shifter shifts left.
REQ-027 spi_miso_o is 0 during CMD, during write frames and whenever CS is deasserted.
REQ-028 Address wrap: after address 15 the next byte targets address 0.
REQ-029 CS rise mid-byte: the partial byte is discarded, no write and no wr_stb_o occur, and frame_done_o pulses only if at least one byte completed.
REQ-030 A CS rise and an edge detected in the same cycle: the CS rise wins.
REQ-031 SPI and local write to the same address in the same cycle: the SPI write wins.
REQ-032 SPI and local write to different addresses in the same cycle: both take effect.
REQ-033 loc_rdata_o = reg[loc_addr_i], with one-cycle latency.

Reset
REQ-034 While rst is high: state IDLE, all registers = REG_RESET, and the counter, address and shifters are 0.
REQ-035 While rst is high: every output is 0, including the frame counter.
REQ-036 Reset mid-frame aborts the frame.
REQ-037 After reset, the block waits for a fresh CS fall; a CS already low at reset release is ignored until it rises.

Configuration
REQ-038 With SPI_SLAVE_STATUS_EN defined: address 15 is a read-only 8-bit frame counter that increments, with wrap, on each frame_done_o.
REQ-039 With SPI_SLAVE_STATUS_EN defined: SPI and local writes to address 15 are ignored, wr_stb_o still pulses, and SPI and local reads of address 15 return the counter.
REQ-040 Without SPI_SLAVE_STATUS_EN: address 15 is an ordinary register and no counter exists.

Structure
REQ-041 Shared package spi_slave_pkg holds ADDR_W=4, DATA_W=8, the CMD_RW_BIT=7 constant and the state enum type.
REQ-042 Sub-module spi_sync_edge holds one synchroniser plus rise/fall detection and is instantiated for SCK and CS; MOSI uses the synchroniser only.

Verification
REQ-043 Write frame 8'h03, 8'hA5, 8'h5A -> reg3=A5 and reg4=5A, two wr_stb_o pulses (addr 3 then 4), one frame_done_o.
REQ-044 After REQ-043, read frame 8'h83 plus two dummy bytes -> MISO returns A5 then 5A, and MISO is 0 during the command byte.
REQ-045 Write starting at address 15 with bytes 11, 22 -> reg15=11 and reg0=22 without the macro; with the macro, reg15 is unchanged and reg0=22.
REQ-046 CS rise after 5 bits of a data byte -> no write, no wr_stb_o, frame_done_o still pulses; CS rise during the command byte -> no frame_done_o.
REQ-047 Local write to address 6 with 8'h77 in the same cycle as an SPI write to address 6 with 8'h99 -> reg6=99; loc_rdata_o shows 99 one cycle after loc_addr_i=6.
REQ-048 rst asserted mid-read with SCK running -> all outputs 0 and state IDLE; the next full frame behaves normally.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared constants and types for the SPI slave register file.
//   ADDR_W / DATA_W : register-file geometry (16 x 8 bit)
//   CMD_RW_BIT      : command-byte bit that selects read (1) or write (0)
//   STATUS_ADDR     : address that becomes the frame counter when the
//                     SPI_SLAVE_STATUS_EN build option is defined
//   state_t         : frame-level state machine encoding
//   dbg_t           : debug view of the state machine and synchronised pins
// -----------------------------------------------------------------------------
package spi_slave_pkg;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int NUM_REGS   = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] STATUS_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [2:0] bit_cnt;
    logic       sck_s;
    logic       cs_n_s;
  } dbg_t;

endpackage

// File: rtl/spi_slave_regfile_if.sv
// -----------------------------------------------------------------------------
// spi_slave_regfile_if
// The four-wire SPI bus plus the slave's MISO output-enable.
//   spi_sck_i     : serial clock, idles low (mode 0)
//   spi_cs_n_i    : active-low chip select
//   spi_mosi_i    : master-out data, MSB first
//   spi_miso_o    : slave-out data
//   spi_miso_oe_o : high while the slave's synchronised chip select is low
// Modports: master (the SPI controller / testbench) and slave (the register
// file). The bus has no valid/ready handshake: a frame is delimited by CS low,
// each bit is qualified by an SCK rising edge, and the controller must keep
// SCK at or below clk/8 so the slave's synchronisers can follow it.
// -----------------------------------------------------------------------------
interface spi_slave_regfile_if;

  logic spi_sck_i;
  logic spi_cs_n_i;
  logic spi_mosi_i;
  logic spi_miso_o;
  logic spi_miso_oe_o;

  modport master (
    output spi_sck_i, spi_cs_n_i, spi_mosi_i,
    input  spi_miso_o, spi_miso_oe_o
  );

  modport slave (
    input  spi_sck_i, spi_cs_n_i, spi_mosi_i,
    output spi_miso_o, spi_miso_oe_o
  );

endinterface

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous input followed by rise/fall
// detection on the synchronised level.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input pin
//   level    : synchronised value (STAGES flops after the pin)
//   rise     : one-cycle pulse on a 0->1 change of level
//   fall     : one-cycle pulse on a 1->0 change of level
// RST_VAL seeds both the chain and the edge-detect history, so no edge is
// reported until the real pin value has propagated through.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// spi_slave_regfile
// SPI mode-0 slave (MSB first) in front of a 16 x 8 register file that is also
// reachable from a local port.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   spi           : SPI bus (slave modport)
//   loc_addr_i    : local address; loc_rdata_o = reg[loc_addr_i] one cycle later
//   loc_we_i      : local write enable, loc_wdata_i : local write data
//   wr_stb_o      : one-cycle pulse after each SPI data-byte write,
//                   with wr_addr_o / wr_data_o
//   frame_done_o  : one-cycle pulse when CS rises after >= 1 complete byte
//   busy_o        : state machine not IDLE
//   dbg_o         : state, bit counter and synchronised SCK/CS levels
// Frame: first byte is the command (bit7 = read, bits 3:0 = start address);
// every following byte reads or writes one register with auto-increment.
// Build option SPI_SLAVE_STATUS_EN: address 15 becomes a read-only 8-bit
// counter of frame_done_o pulses. Without it, address 15 is an ordinary
// register.
// -----------------------------------------------------------------------------
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] REG_RESET   = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  spi_slave_regfile_if.slave  spi,
  input  logic [ADDR_W-1:0]   loc_addr_i,
  input  logic                loc_we_i,
  input  logic [DATA_W-1:0]   loc_wdata_i,
  output logic [DATA_W-1:0]   loc_rdata_o,
  output logic                wr_stb_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic                frame_done_o,
  output logic                busy_o,
  output dbg_t                dbg_o
);

  // ---------------------------------------------------------------------------
  // Pin synchronisation
  // ---------------------------------------------------------------------------
  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.spi_sck_i),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // CS is seeded as "asserted": a CS already low at reset release then never
  // produces a fall, so the slave waits for a real high-then-low sequence.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.spi_cs_n_i),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI goes through the same depth so it stays aligned with SCK edges.
  always_ff @(posedge clk) begin
    if (rst) mosi_q <= '0;
    else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi.spi_mosi_i};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        rx_sh_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [ADDR_W-1:0] addr_q;
  logic              is_read_q;
  logic              byte_seen_q;
  logic              load_pend_q;   // a byte completed; next SCK fall loads TX
  logic              armed_q;       // CS has been seen high since reset
  logic              oe_q;
  logic              wr_stb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              frame_done_q;
  logic [DATA_W-1:0] loc_rdata_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              in_frame;
  logic              byte_end;
  logic              spi_we;
  logic              spi_wr_ok;
  logic              loc_wr_ok;
  logic [DATA_W-1:0] rx_byte;
  logic [DATA_W-1:0] spi_rd_word;
  logic [DATA_W-1:0] loc_rd_word;

  assign in_frame = (state_q != ST_IDLE);
  assign rx_byte  = {rx_sh_q, mosi_s};
  // A CS rise in the same cycle as an SCK edge cancels the edge.
  assign byte_end = in_frame & sck_rise & ~cs_rise & (bit_cnt_q == 3'd7);
  assign spi_we   = byte_end & (state_q == ST_DATA) & ~is_read_q;

`ifdef SPI_SLAVE_STATUS_EN
  logic [DATA_W-1:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt_q <= '0;
    else if (cs_rise && in_frame && byte_seen_q)
      frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign spi_wr_ok = (addr_q != STATUS_ADDR);
  assign loc_wr_ok = (loc_addr_i != STATUS_ADDR);

  always_comb begin
    spi_rd_word = regs_q[addr_q];
    loc_rd_word = regs_q[loc_addr_i];
    if (addr_q == STATUS_ADDR)     spi_rd_word = frame_cnt_q;
    if (loc_addr_i == STATUS_ADDR) loc_rd_word = frame_cnt_q;
  end
`else
  assign spi_wr_ok = 1'b1;
  assign loc_wr_ok = 1'b1;

  always_comb begin
    spi_rd_word = regs_q[addr_q];
    loc_rd_word = regs_q[loc_addr_i];
  end
`endif

  // ---------------------------------------------------------------------------
  // State machine: register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD:  if (sck_rise && bit_cnt_q == 3'd7) state_d = ST_DATA;
        ST_DATA: state_d = ST_DATA;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = in_frame;
    dbg_o  = '{state: state_q, bit_cnt: bit_cnt_q, sck_s: sck_level, cs_n_s: cs_level};
  end

  // ---------------------------------------------------------------------------
  // Register file: the SPI write sits after the local write so it wins on an
  // address collision; different addresses both land.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
    end else begin
      if (loc_we_i && loc_wr_ok) regs_q[loc_addr_i] <= loc_wdata_i;
      if (spi_we && spi_wr_ok)   regs_q[addr_q]     <= rx_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame control, shifters and strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      rx_sh_q      <= '0;
      tx_sh_q      <= '0;
      addr_q       <= '0;
      is_read_q    <= 1'b0;
      byte_seen_q  <= 1'b0;
      load_pend_q  <= 1'b0;
      armed_q      <= 1'b0;
      oe_q         <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      loc_rdata_q  <= '0;
    end else begin
      wr_stb_q     <= 1'b0;
      frame_done_q <= 1'b0;
      armed_q      <= armed_q | cs_level;
      oe_q         <= armed_q & ~cs_level;
      loc_rdata_q  <= loc_rd_word;

      if (cs_rise) begin
        // Partial bytes are simply dropped: nothing was written for them yet.
        frame_done_q <= in_frame & byte_seen_q;
        tx_sh_q      <= '0;
        is_read_q    <= 1'b0;
        load_pend_q  <= 1'b0;
        bit_cnt_q    <= '0;
      end else if (state_q == ST_IDLE) begin
        if (cs_fall) begin
          bit_cnt_q   <= '0;
          rx_sh_q     <= '0;
          tx_sh_q     <= '0;
          addr_q      <= '0;
          is_read_q   <= 1'b0;
          byte_seen_q <= 1'b0;
          load_pend_q <= 1'b0;
        end
      end else begin
        if (sck_rise) begin
          rx_sh_q   <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_seen_q <= 1'b1;
            if (state_q == ST_CMD) begin
              is_read_q   <= rx_byte[CMD_RW_BIT];
              addr_q      <= rx_byte[ADDR_W-1:0];
              load_pend_q <= rx_byte[CMD_RW_BIT];
            end else if (is_read_q) begin
              load_pend_q <= 1'b1;
            end else begin
              wr_stb_q  <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= rx_byte;
              addr_q    <= addr_q + 4'd1;
            end
          end
        end
        // is_read_q is only set once the command byte is done, so this never
        // drives MISO during CMD or in a write frame.
        if (sck_fall && is_read_q) begin
          if (load_pend_q) begin
            tx_sh_q     <= spi_rd_word;
            addr_q      <= addr_q + 4'd1;
            load_pend_q <= 1'b0;
          end else begin
            tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign spi.spi_miso_o    = tx_sh_q[DATA_W-1];
  assign spi.spi_miso_oe_o = oe_q;
  assign loc_rdata_o       = loc_rdata_q;
  assign wr_stb_o          = wr_stb_q;
  assign wr_addr_o         = wr_addr_q;
  assign wr_data_o         = wr_data_q;
  assign frame_done_o      = frame_done_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_regfile
// Directed bench for spi_slave_regfile: an SPI master driven by tasks, a
// wr_stb monitor feeding an observed queue matched against an expected queue,
// local-port readback of register contents, and a final summary line.
// -----------------------------------------------------------------------------
module tb_spi_slave_regfile;
  import spi_slave_pkg::*;

  localparam int SYNC = 2;
  localparam int HALF = 8;   // SCK half period in clk cycles (SCK = clk/16)

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_regfile_if spi();

  logic [3:0] loc_addr;
  logic       loc_we;
  logic [7:0] loc_wdata;
  logic [7:0] loc_rdata;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done;
  logic       busy;
  dbg_t       dbg;

  spi_slave_regfile #(.SYNC_STAGES(SYNC), .REG_RESET(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi.slave),
    .loc_addr_i   (loc_addr),
    .loc_we_i     (loc_we),
    .loc_wdata_i  (loc_wdata),
    .loc_rdata_o  (loc_rdata),
    .wr_stb_o     (wr_stb),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .frame_done_o (frame_done),
    .busy_o       (busy),
    .dbg_o        (dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          fd_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_stb)     obs_q.push_back({wr_addr, wr_data});
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check_wr(input string tag);
    logic [11:0] e;
    logic [11:0] o;
    check_val({tag, "_wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_val({tag, "_wr_stb"}, 32'(o), 32'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_start();
    spi.spi_cs_n_i = 1'b0;
    clk_wait(HALF);
  endtask

  task automatic cs_end();
    clk_wait(HALF);
    spi.spi_cs_n_i = 1'b1;
    clk_wait(2 * HALF);
  endtask

  // Shifts nbits of tx out MSB first and collects MISO just before each rising
  // edge. With collide set, a local write is pulsed in the exact cycle the
  // slave acts on the last rising edge (SYNC+1 clocks after the pin edge).
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          input logic collide, input logic [3:0] c_addr,
                          input logic [7:0] c_data);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi.spi_mosi_i = tx[7-i];
      clk_wait(HALF);
      rx = {rx[6:0], spi.spi_miso_o};
      spi.spi_sck_i = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (collide && i == nbits - 1 && k == SYNC) begin
          loc_addr  = c_addr;
          loc_wdata = c_data;
          loc_we    = 1'b1;
        end else begin
          loc_we = 1'b0;
        end
      end
      spi.spi_sck_i = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx, output logic [7:0] rx);
    spi_byte(tx, 8, rx, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic loc_read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    loc_addr = a;
    clk_wait(1);
    check_val(tag, 32'(loc_rdata), 32'(exp));
  endtask

  task automatic chk_outputs_zero(input string tag);
    check_val({tag, "_wr_stb"},     32'(wr_stb),            32'd0);
    check_val({tag, "_wr_addr"},    32'(wr_addr),           32'd0);
    check_val({tag, "_wr_data"},    32'(wr_data),           32'd0);
    check_val({tag, "_frame_done"}, 32'(frame_done),        32'd0);
    check_val({tag, "_busy"},       32'(busy),              32'd0);
    check_val({tag, "_miso"},       32'(spi.spi_miso_o),    32'd0);
    check_val({tag, "_miso_oe"},    32'(spi.spi_miso_oe_o), 32'd0);
    check_val({tag, "_loc_rdata"},  32'(loc_rdata),         32'd0);
    check_val({tag, "_state"},      32'(dbg.state),         32'(ST_IDLE));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    int         fd0;

    rst            = 1'b1;
    spi.spi_cs_n_i = 1'b1;
    spi.spi_sck_i  = 1'b0;
    spi.spi_mosi_i = 1'b0;
    loc_addr       = 4'h0;
    loc_we         = 1'b0;
    loc_wdata      = 8'h00;

    clk_wait(5);
    chk_outputs_zero("reset");
    rst = 1'b0;
    clk_wait(6);
    check_val("idle_state", 32'(dbg.state), 32'(ST_IDLE));

    // Write frame 03, A5, 5A
    fd0 = fd_cnt;
    exp_q.push_back({4'h3, 8'hA5});
    exp_q.push_back({4'h4, 8'h5A});
    cs_start();
    send(8'h03, rx);
    check_val("wr_cmd_miso", 32'(rx), 32'h00);
    check_val("mid_busy", 32'(busy), 32'd1);
    check_val("mid_oe", 32'(spi.spi_miso_oe_o), 32'd1);
    check_val("mid_state", 32'(dbg.state), 32'(ST_DATA));
    send(8'hA5, rx);
    check_val("wr_data_miso", 32'(rx), 32'h00);
    send(8'h5A, rx);
    cs_end();
    check_wr("write1");
    check_val("write1_fd", 32'(fd_cnt - fd0), 32'd1);
    loc_read_chk("reg3", 4'h3, 8'hA5);
    loc_read_chk("reg4", 4'h4, 8'h5A);

    // Read frame 83 + two dummies
    fd0 = fd_cnt;
    cs_start();
    send(8'h83, rx);
    check_val("rd_cmd_miso", 32'(rx), 32'h00);
    send(8'h00, rx);
    check_val("rd_byte0", 32'(rx), 32'hA5);
    send(8'h00, rx);
    check_val("rd_byte1", 32'(rx), 32'h5A);
    cs_end();
    check_wr("read1");
    check_val("read1_fd", 32'(fd_cnt - fd0), 32'd1);
    check_val("idle_oe", 32'(spi.spi_miso_oe_o), 32'd0);

    // Address wrap from 15
    exp_q.push_back({4'hF, 8'h11});
    exp_q.push_back({4'h0, 8'h22});
    cs_start();
    send(8'h0F, rx);
    send(8'h11, rx);
    send(8'h22, rx);
    cs_end();
    check_wr("wrap");
`ifdef SPI_SLAVE_STATUS_EN
    loc_read_chk("reg15_status", 4'hF, 8'(fd_cnt));
`else
    loc_read_chk("reg15", 4'hF, 8'h11);
`endif
    loc_read_chk("reg0", 4'h0, 8'h22);

    // CS rise after 5 bits of a data byte, then during the command byte
    fd0 = fd_cnt;
    cs_start();
    send(8'h0A, rx);
    spi_byte(8'hFF, 5, rx, 1'b0, 4'h0, 8'h00);
    cs_end();
    check_wr("partial_data");
    check_val("partial_data_fd", 32'(fd_cnt - fd0), 32'd1);
    loc_read_chk("reg10", 4'hA, 8'h00);
    fd0 = fd_cnt;
    cs_start();
    spi_byte(8'h0B, 3, rx, 1'b0, 4'h0, 8'h00);
    cs_end();
    check_wr("partial_cmd");
    check_val("partial_cmd_fd", 32'(fd_cnt - fd0), 32'd0);
    check_val("partial_cmd_busy", 32'(busy), 32'd0);

    // Local write alone
    loc_addr  = 4'hC;
    loc_wdata = 8'h5C;
    loc_we    = 1'b1;
    clk_wait(1);
    loc_we = 1'b0;
    loc_read_chk("reg12_local", 4'hC, 8'h5C);

    // Same-cycle SPI and local writes: same address, then different addresses
    exp_q.push_back({4'h6, 8'h99});
    cs_start();
    send(8'h06, rx);
    spi_byte(8'h99, 8, rx, 1'b1, 4'h6, 8'h77);
    cs_end();
    check_wr("collide_same");
    loc_read_chk("reg6", 4'h6, 8'h99);
    exp_q.push_back({4'h8, 8'h3C});
    cs_start();
    send(8'h08, rx);
    spi_byte(8'h3C, 8, rx, 1'b1, 4'h9, 8'h42);
    cs_end();
    check_wr("collide_diff");
    loc_read_chk("reg8", 4'h8, 8'h3C);
    loc_read_chk("reg9", 4'h9, 8'h42);

    // Reset in the middle of a read with SCK still toggling
    cs_start();
    send(8'h83, rx);
    spi_byte(8'h00, 3, rx, 1'b0, 4'h0, 8'h00);
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      spi.spi_sck_i = 1'b1;
      clk_wait(HALF / 2);
      spi.spi_sck_i = 1'b0;
      clk_wait(HALF / 2);
    end
    chk_outputs_zero("mid_reset");
    obs_q.delete();
    rst = 1'b0;
    clk_wait(4);

    // CS still low after reset: a whole byte of clocks must be ignored
    fd0 = fd_cnt;
    send(8'h03, rx);
    check_val("stale_cs_busy", 32'(busy), 32'd0);
    check_val("stale_cs_state", 32'(dbg.state), 32'(ST_IDLE));
    cs_end();
    check_wr("stale_cs");
    check_val("stale_cs_fd", 32'(fd_cnt - fd0), 32'd0);
    loc_read_chk("reg3_after_rst", 4'h3, 8'h00);

    // Normal operation after reset
    exp_q.push_back({4'h2, 8'hC3});
    cs_start();
    send(8'h02, rx);
    send(8'hC3, rx);
    cs_end();
    check_wr("post_rst_write");
    cs_start();
    send(8'h82, rx);
    check_val("post_rst_cmd_miso", 32'(rx), 32'h00);
    send(8'h00, rx);
    check_val("post_rst_read", 32'(rx), 32'hC3);
    cs_end();
    check_wr("post_rst_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
